// File: rtl/os_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : os_result_drain
// Drain controller for one output-stationary PE column: issues one load pulse
// per tile, then streams the shadow chain out as a valid/ready word stream.
// Optional macro: OS_DRAIN_SAT_EN (signed saturation to OUT_WIDTH, adds out_sat).
// Revision : 1.0
// ============================================================================
module os_result_drain #(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int ROWS      = 4,
  parameter int TILE_ID_W = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    tile_valid,
  output logic                                    tile_ready,
  output logic                                    load_en,
  output logic                                    shift_en,
  input  logic [ACC_WIDTH-1:0]                    acc_shift_in,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [OUT_WIDTH-1:0]                    out_data,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic                                    out_last,
  output logic [TILE_ID_W-1:0]                    out_tile_id,
`ifdef OS_DRAIN_SAT_EN
  output logic                                    out_sat,
`endif
  output logic                                    busy
);

  localparam int c_CW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                 r_state;
  logic [c_CW-1:0]        r_count;
  logic [TILE_ID_W-1:0]   r_tile_id;
  logic                   r_load;
  logic                   r_valid;
  logic                   r_ready;

  logic                   w_last;
  logic [OUT_WIDTH-1:0]   w_conv;
  logic                   w_ovf;
  logic                   w_unused_acc;

  assign w_last = (r_count == c_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_tile_id <= '0;
      r_load    <= 1'b0;
      r_valid   <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (tile_valid) begin
            r_state <= S_LOAD;
            r_load  <= 1'b1;
            r_ready <= 1'b0;
          end
        end
        S_LOAD: begin
          r_state <= S_DRAIN;
          r_load  <= 1'b0;
          r_valid <= 1'b1;
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (w_last) begin
              r_state   <= S_IDLE;
              r_count   <= '0;
              r_tile_id <= r_tile_id + TILE_ID_W'(1);
              r_valid   <= 1'b0;
              r_ready   <= 1'b1;
            end else begin
              r_count <= r_count + c_CW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= '0;
          r_load  <= 1'b0;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Reset masks the strobes in its own cycle so no shift is issued once reset is seen.
  assign tile_ready  = r_ready;
  assign load_en     = r_load & ~rst;
  assign out_valid   = r_valid & ~rst;
  assign shift_en    = r_valid & out_ready & ~rst;
  assign out_row     = c_LAST - r_count;
  assign out_last    = out_valid & w_last;
  assign out_tile_id = r_tile_id;
  assign busy        = (r_state != S_IDLE);

  assign w_unused_acc = ^acc_shift_in;

`ifdef OS_DRAIN_SAT_EN
  generate
    if (OUT_WIDTH < ACC_WIDTH) begin : g_sat
      logic [ACC_WIDTH-OUT_WIDTH:0] w_upper;
      assign w_upper = acc_shift_in[ACC_WIDTH-1:OUT_WIDTH-1];
      // In range only when every bit above the OUT_WIDTH sign bit matches it.
      assign w_ovf   = ~((&w_upper) | ~(|w_upper));
      assign w_conv  = ~w_ovf ? acc_shift_in[OUT_WIDTH-1:0] :
                       acc_shift_in[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                                                   {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else begin : g_pass
      assign w_ovf  = 1'b0;
      assign w_conv = acc_shift_in[OUT_WIDTH-1:0];
    end
  endgenerate
  assign out_sat = out_valid & w_ovf;
`else
  assign w_ovf  = 1'b0;
  assign w_conv = acc_shift_in[OUT_WIDTH-1:0];
`endif

  assign out_data = out_valid ? w_conv : '0;

endmodule
`default_nettype wire

// File: tb/tb_os_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_os_result_drain
// Directed self-checking bench for os_result_drain (ROWS=4/32b, ROWS=4/16b, ROWS=1).
// Revision : 1.0
// ============================================================================
module tb_os_result_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   asserts = 0;
  int   fails   = 0;

  // Main instance: ROWS=4, 32-bit pass-through, driven by a shadow-chain model
  logic        tv, rdy, tr, ld, sh_en, ov, ol, bz;
  logic [31:0] od, acc_in;
  logic [1:0]  orow;
  logic [7:0]  tid;
  logic        osat;

  // Narrow instance: ROWS=4, OUT_WIDTH=16, directly driven input word
  logic        tv16, rdy16, tr16, ld16, sh16, ov16, ol16, bz16;
  logic [31:0] acc16;
  logic [15:0] od16;
  logic [1:0]  orow16;
  logic [7:0]  tid16;
  logic        osat16;

  // Single-row instance
  logic        tv1, rdy1, tr1, ld1, sh1, ov1, ol1, bz1;
  logic [31:0] acc1, od1;
  logic [0:0]  orow1;
  logic [7:0]  tid1;
  logic        osat1;

  os_result_drain #(.ACC_WIDTH(32), .OUT_WIDTH(32), .ROWS(4), .TILE_ID_W(8)) dut (
    .clk(clk), .rst(rst), .tile_valid(tv), .tile_ready(tr), .load_en(ld), .shift_en(sh_en),
    .acc_shift_in(acc_in), .out_valid(ov), .out_ready(rdy), .out_data(od), .out_row(orow),
    .out_last(ol), .out_tile_id(tid),
`ifdef OS_DRAIN_SAT_EN
    .out_sat(osat),
`endif
    .busy(bz));

  os_result_drain #(.ACC_WIDTH(32), .OUT_WIDTH(16), .ROWS(4), .TILE_ID_W(8)) dut16 (
    .clk(clk), .rst(rst), .tile_valid(tv16), .tile_ready(tr16), .load_en(ld16), .shift_en(sh16),
    .acc_shift_in(acc16), .out_valid(ov16), .out_ready(rdy16), .out_data(od16), .out_row(orow16),
    .out_last(ol16), .out_tile_id(tid16),
`ifdef OS_DRAIN_SAT_EN
    .out_sat(osat16),
`endif
    .busy(bz16));

  os_result_drain #(.ACC_WIDTH(32), .OUT_WIDTH(32), .ROWS(1), .TILE_ID_W(8)) dut1 (
    .clk(clk), .rst(rst), .tile_valid(tv1), .tile_ready(tr1), .load_en(ld1), .shift_en(sh1),
    .acc_shift_in(acc1), .out_valid(ov1), .out_ready(rdy1), .out_data(od1), .out_row(orow1),
    .out_last(ol1), .out_tile_id(tid1),
`ifdef OS_DRAIN_SAT_EN
    .out_sat(osat1),
`endif
    .busy(bz1));

`ifndef OS_DRAIN_SAT_EN
  assign osat   = 1'b0;
  assign osat16 = 1'b0;
  assign osat1  = 1'b0;
`endif

  // PE column model: index 0 is the bottom PE feeding the drain
  logic [31:0] shadow [4];
  logic [31:0] tile_vals [4];
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 4; i++) shadow[i] <= tile_vals[i];
    end else if (sh_en) begin
      for (int i = 0; i < 3; i++) shadow[i] <= shadow[i+1];
      shadow[3] <= 32'd0;
    end
  end
  assign acc_in = shadow[0];

  // load_en and shift_en must never coincide on any instance
  always @(negedge clk) begin
    asserts++;
    if ((ld && sh_en) || (ld16 && sh16) || (ld1 && sh1)) begin
      fails++;
      $display("FAIL load_shift_excl: load=%b%b%b shift=%b%b%b required no overlap",
               ld, ld16, ld1, sh_en, sh16, sh1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tv = 0; rdy = 0; tv16 = 0; rdy16 = 0; tv1 = 0; rdy1 = 0;
    acc16 = '0; acc1 = '0;
    for (int i = 0; i < 4; i++) begin shadow[i] = '0; tile_vals[i] = '0; end
    repeat (3) step();
    rst = 1'b0;
    #1;
    asserts++; if (tr !== 1'b1)  begin fails++; $display("FAIL rst_tile_ready: got %b want 1", tr); end
    asserts++; if (bz !== 1'b0)  begin fails++; $display("FAIL rst_busy: got %b want 0", bz); end
    asserts++; if (ov !== 1'b0)  begin fails++; $display("FAIL rst_out_valid: got %b want 0", ov); end
    asserts++; if (ld !== 1'b0 || sh_en !== 1'b0) begin fails++; $display("FAIL rst_strobes: load=%b shift=%b want 0", ld, sh_en); end
    asserts++; if (orow !== 2'd3) begin fails++; $display("FAIL rst_out_row: got %0d want 3", orow); end
    asserts++; if (tid !== 8'd0) begin fails++; $display("FAIL rst_tile_id: got %0d want 0", tid); end
    asserts++; if (ol !== 1'b0 || od !== 32'd0) begin fails++; $display("FAIL rst_last_data: last=%b data=%0h want 0", ol, od); end
    asserts++; if (tr16 !== 1'b1 || bz16 !== 1'b0 || tid16 !== 8'd0) begin fails++; $display("FAIL rst_dut16: ready=%b busy=%b id=%0d want 1/0/0", tr16, bz16, tid16); end
    asserts++; if (tr1 !== 1'b1 || ol1 !== 1'b0 || tid1 !== 8'd0) begin fails++; $display("FAIL rst_dut1: ready=%b last=%b id=%0d want 1/0/0", tr1, ol1, tid1); end
  endtask

  task automatic test_basic();
    logic [31:0] exp_d;
    tile_vals[0] = 32'd40; tile_vals[1] = 32'd30; tile_vals[2] = 32'd20; tile_vals[3] = 32'd10;
    step();
    tv = 1'b1; rdy = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) tv = 1'b0;
      #1;
      asserts++; if (ld !== (k == 1)) begin fails++; $display("FAIL basic_load k=%0d: got %b want %b", k, ld, (k == 1)); end
      asserts++; if (ov !== (k >= 2 && k <= 5)) begin fails++; $display("FAIL basic_valid k=%0d: got %b want %b", k, ov, (k >= 2 && k <= 5)); end
      asserts++; if (tr !== (k == 6)) begin fails++; $display("FAIL basic_tile_ready k=%0d: got %b want %b", k, tr, (k == 6)); end
      if (k >= 2 && k <= 5) begin
        exp_d = 32'd40 - 32'd10 * 32'(k - 2);
        asserts++; if (od !== exp_d) begin fails++; $display("FAIL basic_data k=%0d: got %0d want %0d", k, od, exp_d); end
        asserts++; if (orow !== 2'(5 - k)) begin fails++; $display("FAIL basic_row k=%0d: got %0d want %0d", k, orow, 5 - k); end
        asserts++; if (ol !== (k == 5)) begin fails++; $display("FAIL basic_last k=%0d: got %b want %b", k, ol, (k == 5)); end
        asserts++; if (sh_en !== 1'b1) begin fails++; $display("FAIL basic_shift k=%0d: got %b want 1", k, sh_en); end
      end
    end
  endtask

  task automatic test_backpressure();
    int beat = 0;
    int stalls = 0;
    int kend = 0;
    logic stalled;
    logic [31:0] exp_d [4];
    exp_d[0] = 32'd40; exp_d[1] = 32'd30; exp_d[2] = 32'd20; exp_d[3] = 32'd10;
    step();
    tv = 1'b1; rdy = 1'b1;
    for (int k = 1; k <= 20 && beat < 4; k++) begin
      step();
      tv = 1'b0;
      stalled = ov && (beat == 1) && (stalls < 3);
      rdy = !stalled;
      #1;
      if (stalled) begin
        stalls++;
        asserts++; if (od !== 32'd30) begin fails++; $display("FAIL bp_hold_data: got %0d want 30", od); end
        asserts++; if (sh_en !== 1'b0) begin fails++; $display("FAIL bp_stall_shift: got %b want 0", sh_en); end
      end else if (ov) begin
        asserts++; if (od !== exp_d[beat]) begin fails++; $display("FAIL bp_data beat%0d: got %0d want %0d", beat, od, exp_d[beat]); end
        asserts++; if (sh_en !== 1'b1) begin fails++; $display("FAIL bp_shift beat%0d: got %b want 1", beat, sh_en); end
        beat++;
        kend = k;
      end
    end
    rdy = 1'b1;
    asserts++; if (beat != 4) begin fails++; $display("FAIL bp_beats: got %0d want 4", beat); end
    asserts++; if (kend != 8) begin fails++; $display("FAIL bp_last_cycle: got %0d want 8", kend); end
    step();
    asserts++; if (tr !== 1'b1) begin fails++; $display("FAIL bp_tile_ready: got %b want 1", tr); end
  endtask

  task automatic test_busy_blocking();
    int loads = 0;
    int second_k = 0;
    apply_reset();
    step();
    tv = 1'b1; rdy = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 7) tv = 1'b0;
      #1;
      if (ld) begin loads++; if (loads == 2) second_k = k; end
      if (k >= 2 && k <= 5) begin
        asserts++; if (!ov || tid !== 8'd0) begin fails++; $display("FAIL busy_id_t0 k=%0d: valid=%b id=%0d want 1/0", k, ov, tid); end
      end
      if (k >= 8 && k <= 11) begin
        asserts++; if (!ov || tid !== 8'd1) begin fails++; $display("FAIL busy_id_t1 k=%0d: valid=%b id=%0d want 1/1", k, ov, tid); end
      end
    end
    asserts++; if (loads != 2) begin fails++; $display("FAIL busy_loads: got %0d want 2", loads); end
    asserts++; if (second_k != 7) begin fails++; $display("FAIL busy_second_load: cycle %0d want 7", second_k); end
    asserts++; if (tr !== 1'b1 || tid !== 8'd2) begin fails++; $display("FAIL busy_end: ready=%b id=%0d want 1/2", tr, tid); end
  endtask

  task automatic test_reset_mid_drain();
    step();
    tv = 1'b1; rdy = 1'b1;
    step(); tv = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    asserts++; if (ov !== 1'b0 || sh_en !== 1'b0 || ld !== 1'b0) begin fails++; $display("FAIL rmid_drop: valid=%b shift=%b load=%b want 0", ov, sh_en, ld); end
    step();
    rst = 1'b0;
    #1;
    asserts++; if (ov !== 1'b0 || bz !== 1'b0 || tr !== 1'b1) begin fails++; $display("FAIL rmid_idle: valid=%b busy=%b ready=%b want 0/0/1", ov, bz, tr); end
    asserts++; if (tid !== 8'd0) begin fails++; $display("FAIL rmid_tile_id: got %0d want 0", tid); end
    tv = 1'b1;
    step(); tv = 1'b0;
    step();
    #1;
    asserts++; if (ov !== 1'b1 || od !== 32'd40 || orow !== 2'd3) begin fails++; $display("FAIL rmid_restart: valid=%b data=%0d row=%0d want 1/40/3", ov, od, orow); end
    for (int n = 0; n < 20 && !tr; n++) step();
    asserts++; if (tr !== 1'b1) begin fails++; $display("FAIL rmid_timeout: tile_ready=%b want 1", tr); end
  endtask

  task automatic run_tile();
    tv = 1'b1; rdy = 1'b1;
    step(); tv = 1'b0;
    for (int n = 0; n < 20 && !tr; n++) step();
    asserts++; if (tr !== 1'b1) begin fails++; $display("FAIL tile_timeout: tile_ready=%b want 1", tr); end
  endtask

  task automatic test_tile_id_wrap();
    apply_reset();
    for (int t = 0; t < 255; t++) run_tile();
    asserts++; if (tid !== 8'd255) begin fails++; $display("FAIL wrap_pre: got %0d want 255", tid); end
    tv = 1'b1; rdy = 1'b1;
    step(); tv = 1'b0;
    step();
    asserts++; if (ov !== 1'b1 || tid !== 8'd255) begin fails++; $display("FAIL wrap_beat_id: valid=%b id=%0d want 1/255", ov, tid); end
    for (int n = 0; n < 20 && !tr; n++) step();
    asserts++; if (tr !== 1'b1 || tid !== 8'd0) begin fails++; $display("FAIL wrap_post: ready=%b id=%0d want 1/0", tr, tid); end
  endtask

  task automatic test_width_conv();
    int beat = 0;
    logic [31:0] vin  [4];
    logic [15:0] vexp [4];
    logic        sexp [4];
    vin[0] = 32'h0001_2345; vin[1] = 32'hFFFF_0000; vin[2] = 32'h0000_7FFF; vin[3] = 32'hFFFF_8000;
`ifdef OS_DRAIN_SAT_EN
    vexp[0] = 16'h7FFF; vexp[1] = 16'h8000; vexp[2] = 16'h7FFF; vexp[3] = 16'h8000;
    sexp[0] = 1'b1; sexp[1] = 1'b1; sexp[2] = 1'b0; sexp[3] = 1'b0;
`else
    vexp[0] = 16'h2345; vexp[1] = 16'h0000; vexp[2] = 16'h7FFF; vexp[3] = 16'h8000;
    sexp[0] = 1'b0; sexp[1] = 1'b0; sexp[2] = 1'b0; sexp[3] = 1'b0;
`endif
    step();
    tv16 = 1'b1; rdy16 = 1'b1;
    for (int k = 1; k <= 12 && beat < 4; k++) begin
      step();
      tv16 = 1'b0;
      acc16 = vin[beat];
      #1;
      if (ov16) begin
        asserts++; if (od16 !== vexp[beat]) begin fails++; $display("FAIL conv_data beat%0d: got %h want %h", beat, od16, vexp[beat]); end
        asserts++; if (osat16 !== sexp[beat]) begin fails++; $display("FAIL conv_sat beat%0d: got %b want %b", beat, osat16, sexp[beat]); end
        asserts++; if (orow16 !== 2'(3 - beat) || ol16 !== (beat == 3)) begin fails++; $display("FAIL conv_row beat%0d: row=%0d last=%b", beat, orow16, ol16); end
        beat++;
      end
    end
    asserts++; if (beat != 4) begin fails++; $display("FAIL conv_beats: got %0d want 4", beat); end
  endtask

  task automatic test_rows1();
    acc1 = 32'h0000_0055;
    step();
    tv1 = 1'b1; rdy1 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      tv1 = 1'b0;
      #1;
      asserts++; if (ld1 !== (k == 1)) begin fails++; $display("FAIL r1_load k=%0d: got %b want %b", k, ld1, (k == 1)); end
      asserts++; if (ov1 !== (k == 2) || ol1 !== (k == 2)) begin fails++; $display("FAIL r1_valid_last k=%0d: valid=%b last=%b", k, ov1, ol1); end
      asserts++; if (tr1 !== (k == 3) || bz1 !== (k != 3)) begin fails++; $display("FAIL r1_ready_busy k=%0d: ready=%b busy=%b", k, tr1, bz1); end
      if (k == 2) begin
        asserts++; if (orow1 !== 1'b0 || od1 !== 32'h55 || sh1 !== 1'b1 || osat1 !== 1'b0) begin fails++; $display("FAIL r1_beat: row=%0d data=%h shift=%b sat=%b want 0/55/1/0", orow1, od1, sh1, osat1); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_busy_blocking();
    test_reset_mid_drain();
    test_tile_id_wrap();
    test_width_conv();
    test_rows1();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
`default_nettype wire
